// File: rtl/lsu_mem_port_if.sv
// Data-memory bus between the load/store unit (master) and the memory system (slave).
// One request beat per transaction, then one response beat carrying read data or the write ack.
interface lsu_mem_port_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic                mem_req_valid;
    logic                mem_req_ready;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [XLEN-1:0]     mem_wdata;
    logic [XLEN/8-1:0]   mem_wstrb;
    logic                mem_resp_valid;
    logic [XLEN-1:0]     mem_rdata;

    modport master (
        output mem_req_valid,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output mem_wstrb,
        input  mem_req_ready,
        input  mem_resp_valid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req_valid,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wstrb,
        output mem_req_ready,
        output mem_resp_valid,
        output mem_rdata
    );
endinterface

// File: rtl/lsu_mem_port.sv
// Load/store unit bus port: one outstanding access, lane-shifted stores, sign/zero-extended loads.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning them down.
module lsu_mem_port #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    lsu_mem_port_if.master    mem
);

    localparam int STRB_W = XLEN / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic                we_q, we_d;
    logic [2:0]          op_q, op_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]     wdata_q, wdata_d;
    logic [XLEN-1:0]     rdata_q, rdata_d;
    logic [OFF_W-1:0]    off;

    // Dword and unsigned-word only exist on a 64-bit bus; 111 is never legal.
    function automatic logic op_illegal(input logic [2:0] op);
        case (op)
            3'b111:         return 1'b1;
            3'b011, 3'b110: return (XLEN == 32);
            default:        return 1'b0;
        endcase
    endfunction

    function automatic logic [OFF_W-1:0] size_mask(input logic [2:0] op);
        logic [3:0] m;
        case (op[1:0])
            2'd0:    m = 4'h0;
            2'd1:    m = 4'h1;
            2'd2:    m = 4'h3;
            default: m = 4'h7;
        endcase
        return m[OFF_W-1:0];
    endfunction

    function automatic logic [STRB_W-1:0] size_strb(input logic [2:0] op);
        logic [7:0] s;
        case (op[1:0])
            2'd0:    s = 8'h01;
            2'd1:    s = 8'h03;
            2'd2:    s = 8'h0F;
            default: s = 8'hFF;
        endcase
        return s[STRB_W-1:0];
    endfunction

    // Push the field to the top of the word, then shift back arithmetically or logically.
    function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] lane,
                                                    input logic [2:0]      op);
        int              sh;
        logic [XLEN-1:0] u;
        case (op[1:0])
            2'd0:    sh = XLEN - 8;
            2'd1:    sh = XLEN - 16;
            2'd2:    sh = XLEN - 32;
            default: sh = 0;
        endcase
        u = lane << sh;
        if (op[2]) begin
            return u >> sh;
        end
        return $signed(u) >>> sh;
    endfunction

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        op_d    = op_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    op_d    = req_op;
                    wdata_d = req_wdata;
`ifdef LSU_MISALIGN_TRAP_EN
                    addr_d  = req_addr;
                    err_d   = op_illegal(req_op) ||
                              (|(req_addr[OFF_W-1:0] & size_mask(req_op)));
`else
                    addr_d  = {req_addr[ADDR_W-1:OFF_W],
                               req_addr[OFF_W-1:0] & ~size_mask(req_op)};
                    err_d   = op_illegal(req_op);
`endif
                    state_d = err_d ? RESP : REQ;
                end
            end
            REQ: begin
                if (mem.mem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Stores also wait here: mem_resp_valid doubles as the write ack.
                if (mem.mem_resp_valid) begin
                    if (!we_q) begin
                        rdata_d = mem.mem_rdata;
                    end
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        off               = addr_q[OFF_W-1:0];
        req_ready         = (state_q == IDLE);
        resp_valid        = (state_q == RESP);
        resp_err          = 1'b0;
        resp_rdata        = '0;
        mem.mem_req_valid = 1'b0;
        mem.mem_we        = 1'b0;
        mem.mem_addr      = '0;
        mem.mem_wdata     = '0;
        mem.mem_wstrb     = '0;

        // Bus outputs are only non-zero while the request is on the bus.
        if (state_q == REQ) begin
            mem.mem_req_valid = 1'b1;
            mem.mem_we        = we_q;
            mem.mem_addr      = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            if (we_q) begin
                mem.mem_wdata = wdata_q << {off, 3'b000};
                mem.mem_wstrb = size_strb(op_q) << off;
            end
        end

        if (state_q == RESP) begin
            resp_err = err_q;
            if (!err_q && !we_q) begin
                resp_rdata = load_extend(rdata_q >> {off, 3'b000}, op_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            op_q    <= 3'b000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            op_q    <= op_d;
            err_q   <= err_d;
        end
    end

    // Datapath registers are only observed through state-gated outputs, so they carry no reset.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        rdata_q <= rdata_d;
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Scoreboard bench for lsu_mem_port: a 32-bit and a 64-bit instance driven by directed accesses.
module tb_lsu_mem_port;

    logic clk;
    logic rst_n;

    logic        req_valid, req_ready, req_we, resp_valid, resp_err;
    logic [2:0]  req_op;
    logic [31:0] req_addr, req_wdata, resp_rdata;

    logic        w_req_valid, w_req_ready, w_req_we, w_resp_valid, w_resp_err;
    logic [2:0]  w_req_op;
    logic [31:0] w_req_addr;
    logic [63:0] w_req_wdata, w_resp_rdata;

    lsu_mem_port_if #(.XLEN(32), .ADDR_W(32)) m32 ();
    lsu_mem_port_if #(.XLEN(64), .ADDR_W(32)) m64 ();

    lsu_mem_port #(.XLEN(32), .ADDR_W(32)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem(m32)
    );

    lsu_mem_port #(.XLEN(64), .ADDR_W(32)) dut64 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(w_req_valid), .req_ready(w_req_ready), .req_we(w_req_we), .req_op(w_req_op),
        .req_addr(w_req_addr), .req_wdata(w_req_wdata),
        .resp_valid(w_resp_valid), .resp_rdata(w_resp_rdata), .resp_err(w_resp_err),
        .mem(m64)
    );

    typedef struct {
        logic        err;
        logic [63:0] rdata;
        int          t0;
        int          lat;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    exp_t e32, e64;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resp_valid) begin
            if (q32.size() == 0) begin
                check("r32_spurious", resp_valid, 1'b0);
            end else begin
                e32 = q32.pop_front();
                check("r32_err", resp_err, e32.err);
                check("r32_rdata", resp_rdata, e32.rdata);
                check("r32_lat", cyc - e32.t0, e32.lat);
            end
        end
    end

    always @(negedge clk) begin
        if (w_resp_valid) begin
            if (q64.size() == 0) begin
                check("r64_spurious", w_resp_valid, 1'b0);
            end else begin
                e64 = q64.pop_front();
                check("r64_err", w_resp_err, e64.err);
                check("r64_rdata", w_resp_rdata, e64.rdata);
                check("r64_lat", cyc - e64.t0, e64.lat);
            end
        end
    end

    // Called at a negedge with the 32-bit unit idle; returns at a negedge with it idle again.
    task automatic acc32(input logic we, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata, input int stall,
                         input logic exp_err, input logic [31:0] exp_rdata,
                         input logic [31:0] exp_maddr, input logic [3:0] exp_strb,
                         input logic [31:0] exp_mwdata);
        exp_t e;
        check("a32_ready", req_ready, 1'b1);
        req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = wdata;
        e.err = exp_err; e.rdata = {32'h0, exp_rdata}; e.t0 = cyc;
        e.lat = exp_err ? 1 : 3 + stall;
        q32.push_back(e);
        @(negedge clk);
        if (!exp_err) begin
            req_addr = addr ^ 32'h40;
            for (int i = 0; i <= stall; i++) begin
                check("a32_mreq", m32.mem_req_valid, 1'b1);
                check("a32_maddr", m32.mem_addr, exp_maddr);
                check("a32_strb", m32.mem_wstrb, exp_strb);
                check("a32_mwdata", m32.mem_wdata, exp_mwdata);
                check("a32_mwe", m32.mem_we, we);
                check("a32_busy", req_ready, 1'b0);
                if (i == stall) begin
                    req_valid = 1'b0;
                    m32.mem_req_ready = 1'b1;
                end
                @(negedge clk);
            end
            m32.mem_req_ready = 1'b0;
            m32.mem_resp_valid = 1'b1;
            m32.mem_rdata = rdata;
            check("a32_wait_mreq", m32.mem_req_valid, 1'b0);
            @(negedge clk);
            m32.mem_resp_valid = 1'b0;
        end else begin
            req_valid = 1'b0;
            check("a32_err_nobus", m32.mem_req_valid, 1'b0);
        end
        for (int i = 0; i < 8 && q32.size() != 0; i++) @(posedge clk);
        check("a32_drain", q32.size(), 0);
        @(negedge clk);
    endtask

    task automatic acc64(input logic we, input logic [2:0] op, input logic [31:0] addr,
                         input logic [63:0] wdata, input logic [63:0] rdata,
                         input logic exp_err, input logic [63:0] exp_rdata,
                         input logic [31:0] exp_maddr, input logic [7:0] exp_strb,
                         input logic [63:0] exp_mwdata);
        exp_t e;
        check("a64_ready", w_req_ready, 1'b1);
        w_req_valid = 1'b1; w_req_we = we; w_req_op = op; w_req_addr = addr; w_req_wdata = wdata;
        e.err = exp_err; e.rdata = exp_rdata; e.t0 = cyc; e.lat = exp_err ? 1 : 3;
        q64.push_back(e);
        @(negedge clk);
        w_req_valid = 1'b0;
        if (!exp_err) begin
            check("a64_mreq", m64.mem_req_valid, 1'b1);
            check("a64_maddr", m64.mem_addr, exp_maddr);
            check("a64_strb", m64.mem_wstrb, exp_strb);
            check("a64_mwdata", m64.mem_wdata, exp_mwdata);
            m64.mem_req_ready = 1'b1;
            @(negedge clk);
            m64.mem_req_ready = 1'b0;
            m64.mem_resp_valid = 1'b1;
            m64.mem_rdata = rdata;
            @(negedge clk);
            m64.mem_resp_valid = 1'b0;
        end else begin
            check("a64_err_nobus", m64.mem_req_valid, 1'b0);
        end
        for (int i = 0; i < 8 && q64.size() != 0; i++) @(posedge clk);
        check("a64_drain", q64.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_op = 3'b000; req_addr = '0; req_wdata = '0;
        w_req_valid = 1'b0; w_req_we = 1'b0; w_req_op = 3'b000; w_req_addr = '0; w_req_wdata = '0;
        m32.mem_req_ready = 1'b0; m32.mem_resp_valid = 1'b0; m32.mem_rdata = '0;
        m64.mem_req_ready = 1'b0; m64.mem_resp_valid = 1'b0; m64.mem_rdata = '0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("rst_ready", req_ready, 1'b1);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_resp_err", resp_err, 1'b0);
        check("rst_mreq", m32.mem_req_valid, 1'b0);
        check("rst_mwe", m32.mem_we, 1'b0);
        check("rst_strb", m32.mem_wstrb, 0);
        check("rst_maddr", m32.mem_addr, 0);
        check("rst_mwdata", m32.mem_wdata, 0);
        check("rst_ready64", w_req_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 32-bit: we, op, addr, wdata, rdata, stall, err, rdata_exp, maddr, strb, mwdata
        acc32(1'b0, 3'b000, 32'h103, 32'h0, 32'h8000_0000, 0, 1'b0, 32'hFFFF_FF80, 32'h100, 4'h0, 32'h0);
        acc32(1'b1, 3'b001, 32'h202, 32'h0000_BEEF, 32'hDEAD_BEEF, 0, 1'b0, 32'h0, 32'h200, 4'hC, 32'hBEEF_0000);
        acc32(1'b0, 3'b101, 32'h0, 32'h0, 32'h1234_F00D, 3, 1'b0, 32'h0000_F00D, 32'h0, 4'h0, 32'h0);
        acc32(1'b0, 3'b001, 32'h2, 32'h0, 32'h8001_0000, 0, 1'b0, 32'hFFFF_8001, 32'h0, 4'h0, 32'h0);
        acc32(1'b0, 3'b100, 32'h101, 32'h0, 32'h0000_AB00, 0, 1'b0, 32'h0000_00AB, 32'h100, 4'h0, 32'h0);
        acc32(1'b1, 3'b000, 32'h3, 32'h1234_5678, 32'h0, 2, 1'b0, 32'h0, 32'h0, 4'h8, 32'h7800_0000);
        acc32(1'b1, 3'b010, 32'h10, 32'hA5A5_A5A5, 32'h0, 0, 1'b0, 32'h0, 32'h10, 4'hF, 32'hA5A5_A5A5);
        acc32(1'b0, 3'b111, 32'h20, 32'h0, 32'h0, 0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h0);
        acc32(1'b1, 3'b011, 32'h8, 32'h1, 32'h0, 0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h0);
        acc32(1'b0, 3'b110, 32'h4, 32'h0, 32'h0, 0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        acc32(1'b0, 3'b010, 32'h2, 32'h0, 32'h0, 0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h0);
        acc32(1'b1, 3'b001, 32'h5, 32'hBEEF, 32'h0, 0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h0);
`else
        acc32(1'b0, 3'b010, 32'h2, 32'h0, 32'hCAFE_BABE, 0, 1'b0, 32'hCAFE_BABE, 32'h0, 4'h0, 32'h0);
        acc32(1'b1, 3'b001, 32'h5, 32'hBEEF, 32'h0, 0, 1'b0, 32'h0, 32'h4, 4'h3, 32'h0000_BEEF);
`endif

        // 64-bit: we, op, addr, wdata, rdata, err, rdata_exp, maddr, strb, mwdata
        acc64(1'b1, 3'b011, 32'h8, 64'h1122_3344_5566_7788, 64'h0, 1'b0, 64'h0, 32'h8, 8'hFF, 64'h1122_3344_5566_7788);
        acc64(1'b0, 3'b111, 32'h8, 64'h0, 64'h0, 1'b1, 64'h0, 32'h0, 8'h00, 64'h0);
        acc64(1'b0, 3'b011, 32'h10, 64'h0, 64'h8000_0000_0000_0001, 1'b0, 64'h8000_0000_0000_0001, 32'h10, 8'h00, 64'h0);
        acc64(1'b0, 3'b110, 32'h4, 64'h0, 64'h8000_0000_0000_0000, 1'b0, 64'h0000_0000_8000_0000, 32'h0, 8'h00, 64'h0);
        acc64(1'b0, 3'b010, 32'h4, 64'h0, 64'h8000_0000_0000_0000, 1'b0, 64'hFFFF_FFFF_8000_0000, 32'h0, 8'h00, 64'h0);
        acc64(1'b1, 3'b000, 32'h7, 64'hAB, 64'h0, 1'b0, 64'h0, 32'h0, 8'h80, 64'hAB00_0000_0000_0000);
        acc64(1'b1, 3'b001, 32'h16, 64'h1234, 64'h0, 1'b0, 64'h0, 32'h10, 8'hC0, 64'h1234_0000_0000_0000);

        // Reset while waiting for the bus response, then a stale response after release.
        req_valid = 1'b1; req_we = 1'b0; req_op = 3'b010; req_addr = 32'h20;
        @(negedge clk);
        req_valid = 1'b0;
        check("mid_mreq", m32.mem_req_valid, 1'b1);
        m32.mem_req_ready = 1'b1;
        @(negedge clk);
        m32.mem_req_ready = 1'b0;
        check("mid_busy", req_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", req_ready, 1'b1);
        check("mid_rst_mreq", m32.mem_req_valid, 1'b0);
        check("mid_rst_resp", resp_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        m32.mem_resp_valid = 1'b1;
        m32.mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        m32.mem_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stale_no_resp", resp_valid, 1'b0);
            @(negedge clk);
        end
        check("stale_ready", req_ready, 1'b1);
        check("stale_mreq", m32.mem_req_valid, 1'b0);

        acc32(1'b0, 3'b100, 32'h102, 32'h0, 32'h00FE_0000, 0, 1'b0, 32'h0000_00FE, 32'h100, 4'h0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
